// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes and state encoding
// for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DATA,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE,
    S_ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extract/extend, store merge
// and access fault classification.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  bsh;
  logic [4:0]  hsh;

  // select addressed byte/halfword, then extend
  always_comb begin
    ld_byte = mem_rd[7:0];
    unique case (addr)
      2'd0: ld_byte = mem_rd[7:0];
      2'd1: ld_byte = mem_rd[15:8];
      2'd2: ld_byte = mem_rd[23:16];
      2'd3: ld_byte = mem_rd[31:24];
      default: ld_byte = mem_rd[7:0];
    endcase
    ld_half = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h0, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0, ld_half};
      default: load_data = mem_rd;
    endcase
  end

  // merge store data into the word read back
  always_comb begin
    bsh = {addr, 3'b000};
    hsh = {addr[1], 4'b0000};
    unique case (funct3)
      F3_B: store_word = (mem_rd & ~(32'h0000_00ff << bsh))
                       | ({24'h0, wdata[7:0]} << bsh);
      F3_H: store_word = (mem_rd & ~(32'h0000_ffff << hsh))
                       | ({16'h0, wdata[15:0]} << hsh);
      default: store_word = wdata;
    endcase
  end

  // misaligned / illegal classification
  always_comb begin
    misaligned = 1'b0;
    if (funct3 == F3_H || funct3 == F3_HU)
      misaligned = addr[0];
    else if (funct3 == F3_W)
      misaligned = (addr != 2'b00);
    if (we)
      illegal = !(funct3 == F3_B || funct3 == F3_H
                  || funct3 == F3_W);
    else
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences RV32I loads/stores onto a
// word-wide data_mem, sub-word stores as RMW.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              idle;
  logic              accept;
  logic              al_we;
  logic [2:0]        al_f3;
  logic [1:0]        al_addr;
  logic [31:0]       al_wdata;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              misaligned;
  logic              illegal;

  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle & ~rst;
  assign accept    = req_valid & req_ready;

  // In IDLE the aligner classifies the incoming
  // request; afterwards it works on the latched one.
  assign al_we    = idle ? req_we        : we_q;
  assign al_f3    = idle ? req_funct3    : f3_q;
  assign al_addr  = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_wdata = idle ? req_wdata     : wdata_q;

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_f3),
    .addr       (al_addr),
    .mem_rd     (mem_rd),
    .wdata      (al_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // state and request latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // next state and request capture on acceptance
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = req_we;
      f3_d    = req_funct3;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned | illegal)
            state_d = S_ERR;
          else if (!req_we)
            state_d = S_RD_ISSUE;
          else if (req_funct3 == F3_W)
            state_d = S_WR;
          else
            state_d = S_RMW_RD;
        end
      end
      S_RD_ISSUE: state_d = S_RD_DATA;
      S_RD_DATA:  state_d = S_IDLE;
      S_WR:       state_d = S_DONE;
      S_RMW_RD:   state_d = S_RMW_WR;
      S_RMW_WR:   state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // output decode; reset kills strobes immediately
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_a      = {addr_q[ADDR_W-1:2], 2'b00};
    if (!rst) begin
      unique case (state_q)
        S_RD_ISSUE: mem_en = 1'b1;
        S_RMW_RD:   mem_en = 1'b1;
        S_RD_DATA: begin
          resp_valid = 1'b1;
          resp_rdata = load_data;
        end
        S_WR, S_RMW_WR: begin
          mem_we = 1'b1;
          mem_wd = store_word;
        end
        S_DONE: resp_valid = 1'b1;
        S_ERR: begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against
// a behavioural word-wide data_mem.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem: registered read, held while en=0
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    if (mem_en) mem_rd <= mem[mem_a[5:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present a request; returns at the cycle-1 sample point
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c0_ready", {31'h0, req_ready}, 32'd1);
    chk("c0_mem_we", {31'h0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_c1_en"}, {31'h0, mem_en}, 32'd1);
    chk({tag, "_c1_we"}, {31'h0, mem_we}, 32'd0);
    chk({tag, "_c1_rv"}, {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_c2_rv"}, {31'h0, resp_valid}, 32'd1);
    chk({tag, "_c2_err"}, {31'h0, resp_err}, 32'd0);
    chk({tag, "_c2_data"}, resp_rdata, exp);
    chk({tag, "_c2_en"}, {31'h0, mem_en}, 32'd0);
    @(negedge clk);
    chk({tag, "_c3_ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, "_c3_rv"}, {31'h0, resp_valid}, 32'd0);
  endtask

  task automatic do_rmw(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expwd);
    issue(1'b1, f3, a, d);
    chk({tag, "_c1_en"}, {31'h0, mem_en}, 32'd1);
    chk({tag, "_c1_we"}, {31'h0, mem_we}, 32'd0);
    chk({tag, "_c1_rv"}, {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_c2_we"}, {31'h0, mem_we}, 32'd1);
    chk({tag, "_c2_en"}, {31'h0, mem_en}, 32'd0);
    chk({tag, "_c2_wd"}, mem_wd, expwd);
    chk({tag, "_c2_rv"}, {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_c3_rv"}, {31'h0, resp_valid}, 32'd1);
    chk({tag, "_c3_err"}, {31'h0, resp_err}, 32'd0);
    chk({tag, "_c3_we"}, {31'h0, mem_we}, 32'd0);
    chk({tag, "_c3_data"}, resp_rdata, 32'h0);
    @(negedge clk);
    chk({tag, "_c4_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  task automatic do_err(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a);
    issue(we, f3, a, 32'hDEAD_BEEF);
    chk({tag, "_c1_rv"}, {31'h0, resp_valid}, 32'd1);
    chk({tag, "_c1_err"}, {31'h0, resp_err}, 32'd1);
    chk({tag, "_c1_data"}, resp_rdata, 32'h0);
    chk({tag, "_c1_en"}, {31'h0, mem_en}, 32'd0);
    chk({tag, "_c1_we"}, {31'h0, mem_we}, 32'd0);
    @(negedge clk);
    chk({tag, "_c2_ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, "_c2_rv"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, "_c2_en"}, {31'h0, mem_en}, 32'd0);
    chk({tag, "_c2_we"}, {31'h0, mem_we}, 32'd0);
  endtask

  initial begin
    logic [9:0] e_rdy;
    logic [9:0] e_rv;
    logic [9:0] e_we;
    logic [9:0] e_en;
    logic [31:0] e_data;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899_AABB;

    // reset state
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_en", {31'h0, mem_en}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_rv", {31'h0, resp_valid}, 32'd0);
    chk("rst_err", {31'h0, resp_err}, 32'd0);
    chk("rst_data", resp_rdata, 32'h0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'h0, req_ready}, 32'd1);

    // SW then LW
    issue(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D);
    chk("sw_c1_we", {31'h0, mem_we}, 32'd1);
    chk("sw_c1_en", {31'h0, mem_en}, 32'd0);
    chk("sw_c1_a", mem_a, 32'h10);
    chk("sw_c1_wd", mem_wd, 32'hCAFE_F00D);
    chk("sw_c1_rv", {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("sw_c2_we", {31'h0, mem_we}, 32'd0);
    chk("sw_c2_rv", {31'h0, resp_valid}, 32'd1);
    chk("sw_c2_err", {31'h0, resp_err}, 32'd0);
    chk("sw_c2_data", resp_rdata, 32'h0);
    @(negedge clk);
    chk("sw_c3_ready", {31'h0, req_ready}, 32'd1);
    do_load("lw10", 3'b010, 32'h10, 32'hCAFE_F00D);

    // loads from preset word
    do_load("lb5", 3'b000, 32'h5, 32'hFFFF_FFAA);
    do_load("lbu5", 3'b100, 32'h5, 32'h0000_00AA);
    do_load("lh6", 3'b001, 32'h6, 32'hFFFF_8899);
    do_load("lhu6", 3'b101, 32'h6, 32'h0000_8899);
    do_load("lw4", 3'b010, 32'h4, 32'h8899_AABB);

    // sub-word stores
    do_rmw("sb7", 3'b000, 32'h7, 32'h1234_5611, 32'h1199_AABB);
    chk("sb7_mem", mem[1], 32'h1199_AABB);
    do_rmw("sh4", 3'b001, 32'h4, 32'h0000_BEEF, 32'h1199_BEEF);
    chk("sh4_mem", mem[1], 32'h1199_BEEF);

    // faults
    do_err("sh3", 1'b1, 3'b001, 32'h3);
    do_err("lw6", 1'b0, 3'b010, 32'h6);
    do_err("ld011", 1'b0, 3'b011, 32'h4);
    do_err("sbu", 1'b1, 3'b100, 32'h4);
    chk("err_mem", mem[1], 32'h1199_BEEF);

    // reset in RMW_WR of SB 0x4
    issue(1'b1, 3'b000, 32'h4, 32'h0000_0055);
    chk("rrst_c1_en", {31'h0, mem_en}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rrst_c2_we", {31'h0, mem_we}, 32'd0);
    chk("rrst_c2_en", {31'h0, mem_en}, 32'd0);
    chk("rrst_c2_rv", {31'h0, resp_valid}, 32'd0);
    chk("rrst_c2_ready", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rrst_c3_rv", {31'h0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rrst_c4_ready", {31'h0, req_ready}, 32'd1);
    chk("rrst_c4_rv", {31'h0, resp_valid}, 32'd0);
    chk("rrst_mem", mem[1], 32'h1199_BEEF);

    // back-to-back with valid held high
    e_rdy = 10'b10_0100_1000;
    e_rv  = 10'b01_0010_0100;
    e_we  = 10'b00_0000_0010;
    e_en  = 10'b00_1001_0000;
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h1122_3344;
    req_valid  = 1'b1;
    chk("b2b_c0_ready", {31'h0, req_ready}, 32'd1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e_data = 32'h0;
      if (c == 5) e_data = 32'h1122_3344;
      if (c == 8) e_data = 32'h0000_0022;
      chk($sformatf("b2b_rdy_c%0d", c),
          {31'h0, req_ready}, {31'h0, e_rdy[c]});
      chk($sformatf("b2b_rv_c%0d", c),
          {31'h0, resp_valid}, {31'h0, e_rv[c]});
      chk($sformatf("b2b_we_c%0d", c),
          {31'h0, mem_we}, {31'h0, e_we[c]});
      chk($sformatf("b2b_en_c%0d", c),
          {31'h0, mem_en}, {31'h0, e_en[c]});
      chk($sformatf("b2b_data_c%0d", c), resp_rdata, e_data);
      if (c == 1) begin
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
      end
      if (c == 4) begin
        req_funct3 = 3'b100;
        req_addr   = 32'h22;
      end
      if (c == 7) req_valid = 1'b0;
    end
    chk("b2b_mem", mem[8], 32'h1122_3344);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
